// File: rtl/trace_cycle_monitor_pkg.sv
// Shared types and default constants for the trace cycle monitor.
// State encoding, default widths and drain-counter sizing helper.
package trace_cycle_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_CNT_W        = 32;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_LIMIT        = 5;
    localparam int DEF_DRAIN_CYCLES = 2;

    // Drain counter only ever holds DRAIN_CYCLES-1 down to 0.
    function automatic int drain_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_mon_chan_cnt.sv
// One saturating event counter with synchronous clear and a sticky
// saturation flag that sets when the count reaches all-ones.
module trace_mon_chan_cnt
    import trace_cycle_monitor_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (en) begin
            if (cnt == MAX) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
                if (cnt == MAX - W'(1))
                    sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_cycle_monitor.sv
// Traced cycle counter with run limit, per-channel event counters and drain.
// Define TRACE_CYCLE_MONITOR_FINISH_EN to print a banner and $finish on DONE entry.
module trace_cycle_monitor
    import trace_cycle_monitor_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
    parameter int DEFAULT_LIMIT = DEF_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop_req,
    input  logic [CNT_W-1:0]        limit,
    input  logic [NUM_CH-1:0]       ch_event,
    output logic [CNT_W-1:0]        cyc,
    output logic [NUM_CH*CNT_W-1:0] ch_count,
    output logic [NUM_CH-1:0]       ch_sat,
    output logic                    busy,
    output logic                    done,
    output logic                    stop_by_limit
);

    localparam int DW = drain_w(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEFAULT_LIMIT);

    state_e           state;
    state_e           state_d;
    logic [CNT_W-1:0] limit_q;
    logic [DW-1:0]    drain_cnt;
    logic             accept;
    logic             leave;
    logic             hit;
    logic             cnt_en;

    assign hit    = (cyc == limit_q);
    assign cnt_en = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        leave   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (hit || stop_req) begin
                    leave   = 1'b1;
                    state_d = (DRAIN_CYCLES > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc           <= '0;
            limit_q       <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            stop_by_limit <= 1'b0;
        end else begin
            busy <= (state_d == RUN) || (state_d == DRAIN);
            done <= (state_d == DONE);
            if (accept) begin
                cyc           <= '0;
                limit_q       <= (limit == '0) ? DEF_LIM : limit;
                stop_by_limit <= 1'b0;
            end else if (state == RUN && !leave) begin
                cyc <= cyc + CNT_W'(1);
            end
            // A limit match wins over a coincident stop_req.
            if (leave) begin
                stop_by_limit <= hit;
                drain_cnt     <= DRAIN_LOAD;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        trace_mon_chan_cnt #(
            .W(CNT_W)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .clr(accept),
            .en (cnt_en && ch_event[i]),
            .cnt(ch_count[i*CNT_W +: CNT_W]),
            .sat(ch_sat[i])
        );
    end

`ifdef TRACE_CYCLE_MONITOR_FINISH_EN
    always_ff @(posedge clk) begin
        if (!rst && state != DONE && state_d == DONE) begin
            $display("*-* All Finished *-*");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_trace_cycle_monitor.sv
// Scoreboard bench: driver pushes per-run expectations from a run-level
// model, monitor pops and compares when done rises and while it is held.
module tb_trace_cycle_monitor;

    localparam int W    = 4;
    localparam int NCH  = 4;
    localparam int DR   = 2;
    localparam int DL   = 5;
    localparam int MAXC = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop_req;
    logic [W-1:0]     limit;
    logic [NCH-1:0]   ch_event;
    logic [W-1:0]     cyc;
    logic [NCH*W-1:0] ch_count;
    logic [NCH-1:0]   ch_sat;
    logic             busy;
    logic             done;
    logic             stop_by_limit;

    trace_cycle_monitor #(
        .CNT_W(W),
        .NUM_CH(NCH),
        .DRAIN_CYCLES(DR),
        .DEFAULT_LIMIT(DL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop_req(stop_req),
        .limit(limit),
        .ch_event(ch_event),
        .cyc(cyc),
        .ch_count(ch_count),
        .ch_sat(ch_sat),
        .busy(busy),
        .done(done),
        .stop_by_limit(stop_by_limit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               cyc;
        logic [NCH*W-1:0] cnt;
        logic [NCH-1:0]   sat;
        logic             sbl;
        int               n0;
        int               lat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ecnt     = 0;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        ecnt++;
    end

    // Monitor: pop on done rising, then verify outputs hold while done stays high.
    initial begin
        exp_t cur;
        bit   have;
        logic done_q;
        have   = 0;
        done_q = 1'b0;
        cur    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 0;
            end else if (done && !done_q) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    cur  = q.pop_front();
                    have = 1;
                    chk("done_latency", ecnt - cur.n0, cur.lat);
                    chk("final_cyc", int'(cyc), cur.cyc);
                    chk("final_counts", int'(ch_count), int'(cur.cnt));
                    chk("final_sat", int'(ch_sat), int'(cur.sat));
                    chk("stop_by_limit", int'(stop_by_limit), int'(cur.sbl));
                    chk("busy_in_done", int'(busy), 0);
                end
            end else if (done && have) begin
                chk("hold_cyc", int'(cyc), cur.cyc);
                chk("hold_counts", int'(ch_count), int'(cur.cnt));
                chk("hold_sat", int'(ch_sat), int'(cur.sat));
                chk("hold_sbl", int'(stop_by_limit), int'(cur.sbl));
            end
            done_q = done;
        end
    end

    function automatic logic [NCH-1:0] gen_ev(input int mode, input int j);
        logic [NCH-1:0] v;
        v = '0;
        case (mode)
            1: begin
                v[0] = 1'b1;
                v[2] = (j % 2 == 0);
            end
            2: v[1] = 1'b1;
            3: v = NCH'($urandom);
            default: v = '0;
        endcase
        return v;
    endfunction

    // One run: start, optional stop_req when cyc==stopk, optional start pokes while busy.
    task automatic run(input int lim, input int stopk, input int mode, input bit poke);
        logic [NCH-1:0] ev[64];
        exp_t e;
        int   eff, fin, tot, n;
        eff = (lim == 0) ? DL : lim;
        fin = (stopk >= 0 && stopk < eff) ? stopk : eff;
        tot = fin + DR + 4;
        for (int j = 0; j < tot; j++) ev[j] = gen_ev(mode, j);
        e     = '0;
        e.cyc = fin;
        e.sbl = (fin == eff);
        e.lat = fin + DR + 1;
        for (int c = 0; c < NCH; c++) begin
            n = 0;
            for (int j = 0; j <= fin + DR; j++) n += int'(ev[j][c]);
            e.cnt[c*W +: W] = W'((n > MAXC) ? MAXC : n);
            e.sat[c]        = (n >= MAXC);
        end
        repeat (2) begin
            @(negedge clk);
            ch_event = NCH'($urandom);
        end
        @(negedge clk);
        start    = 1'b1;
        limit    = W'(lim);
        stop_req = 1'b0;
        ch_event = NCH'($urandom);
        for (int j = 0; j < tot; j++) begin
            @(negedge clk);
            if (j == 0) begin
                e.n0 = ecnt;
                q.push_back(e);
            end
            if (j <= fin) begin
                chk("run_busy", int'(busy), 1);
                chk("run_cyc", int'(cyc), j);
            end else if (j <= fin + DR) begin
                chk("drain_busy", int'(busy), 1);
                chk("drain_cyc", int'(cyc), fin);
            end else begin
                chk("done_flag", int'(done), 1);
            end
            if (j <= fin + DR) chk("no_done_busy", int'(done), 0);
            ch_event = ev[j];
            stop_req = (j == stopk);
            start    = poke && (j == 1 || j == fin + 1);
            limit    = W'($urandom);
        end
        @(negedge clk);
        start    = 1'b0;
        stop_req = 1'b0;
        chk("scoreboard_drained", q.size(), 0);
    endtask

    task automatic reset_check(input string nm);
        chk({nm, "_cyc"}, int'(cyc), 0);
        chk({nm, "_cnt"}, int'(ch_count), 0);
        chk({nm, "_sat"}, int'(ch_sat), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_sbl"}, int'(stop_by_limit), 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        stop_req = 1'b1;
        limit    = '0;
        ch_event = '1;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst      = 1'b0;
        start    = 1'b0;
        stop_req = 1'b0;
        ch_event = '0;

        run(0, -1, 0, 0);
        run(10, 3, 3, 1);
        run(4, -1, 1, 0);
        run(15, -1, 2, 1);
        run(6, 6, 3, 0);
        run(3, 0, 3, 1);
        run(15, 20, 1, 0);

        // Reset in the middle of a run.
        @(negedge clk);
        start    = 1'b1;
        limit    = W'(10);
        ch_event = '1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_cyc", int'(cyc), 2);
        rst = 1'b1;
        @(negedge clk);
        reset_check("midrun_reset");
        rst      = 1'b0;
        ch_event = '0;

        for (int r = 0; r < 30; r++) begin
            run($urandom_range(0, 15),
                ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 16),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3,
                1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_cycle_monitor.md
Name: trace_cycle_monitor

Overview:
- Parametrised successor to the fixed-limit cycle counter used in the tracing examples.
- Provides a free-running traced cycle counter with a programmable run limit, NUM_CH saturating per-channel event counters, an explicit start/stop handshake, and a drain phase before completion.
- Sits beside the DUT in example and regression tops; its counters are the signals exposed to trace.

Parameters:
- CNT_W, 32: width of the cycle counter, limit input and each channel counter.
- NUM_CH, 4: number of event channels (>=1).
- DRAIN_CYCLES, 2: cycles spent in DRAIN after the stop condition (0 allowed).
- DEFAULT_LIMIT, 5: run limit used when limit input is 0 at start.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start pulse; sampled in IDLE or DONE.
- stop_req  in  1  early-stop request; sampled in RUN.
- limit  in  CNT_W  run length; latched on an accepted start.
- ch_event  in  NUM_CH  per-channel event strobes.
- cyc  out  CNT_W  cycle count of the current run.
- ch_count  out  NUM_CH*CNT_W  packed channel counts; channel i at [i*CNT_W +: CNT_W].
- ch_sat  out  NUM_CH  sticky per-channel saturation flags.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- stop_by_limit  out  1  in DONE: 1 = limit reached, 0 = stop_req.

Behaviour:
- Reset: state IDLE; cyc, ch_count, ch_sat, busy, done, stop_by_limit, limit_q and drain counter all 0. rst has priority over every other input, including mid-run.
- States: IDLE, RUN, DRAIN, DONE. busy and done are registered decodes of the state.
- IDLE/DONE, start=1:
  - Next state RUN.
  - Clear cyc, ch_count and ch_sat.
  - limit_q = (limit==0) ? DEFAULT_LIMIT : limit.
  - done drops in the same cycle busy rises.
- RUN:
  - cyc increments by 1 each cycle.
  - If the registered cyc == limit_q, or stop_req=1: cyc holds (no increment) and the block leaves RUN.
    - Next state DRAIN (DRAIN_CYCLES>0) or DONE (DRAIN_CYCLES==0).
    - stop_by_limit = (cyc==limit_q). A simultaneous limit match and stop_req reports 1.
  - start is ignored in RUN and DRAIN.
- DRAIN:
  - Drain counter loaded with DRAIN_CYCLES-1 on entry; decrements each cycle.
  - Next state DONE when the counter is 0. cyc is frozen.
- DONE: all outputs hold until start or rst.
- Channel counters:
  - ch_count[i] increments when ch_event[i]=1 and the state is RUN or DRAIN.
  - Events in IDLE or DONE are ignored.
  - At all-ones the counter holds and ch_sat[i] sets (sticky until start or rst).
  - All channels update independently in the same cycle.
- Latency with start at cycle t, limit=5, DRAIN_CYCLES=2:
  - busy=1 and cyc=0 at t+1.
  - cyc=5 at t+6.
  - DRAIN at t+7 and t+8.
  - done=1 at t+9.
- Width rule: limit_q is CNT_W wide; limit = all-ones is legal. cyc never wraps because it stops at limit_q.

Optional Feature:
- Macro TRACE_CYCLE_MONITOR_FINISH_EN.
- When defined, on entry to DONE the block:
  - prints "*-* All Finished *-*" with $display;
  - calls $finish;
  - both are non-synthesizable, in a clocked block guarded by the macro.
- When undefined, no system tasks are present; completion is signalled only by done, and the enclosing top decides when to end simulation.

Decomposition:
- Package trace_cycle_monitor_pkg holds:
  - state enum type (IDLE, RUN, DRAIN, DONE, 2-bit encoding);
  - default constants for CNT_W, DEFAULT_LIMIT and DRAIN_CYCLES.
- Sub-module trace_mon_chan_cnt: one saturating CNT_W counter with clear, enable and sticky-saturation flag. It is instantiated NUM_CH times in a generate loop.
- The top keeps the FSM, cyc, limit_q and the drain counter.

Test Plan:
- rst asserted 3 cycles, then start pulse with limit=0 and no events -> busy at t+1; cyc counts 0..5; done=1 at t+9; stop_by_limit=1; cyc stays 5; all ch_count=0.
- limit=10, stop_req pulsed when cyc=3 -> cyc frozen at 3; DRAIN 2 cycles; done=1; stop_by_limit=0.
- limit=4, ch_event[0] every cycle and ch_event[2] every other cycle, with ch_event also driven in IDLE and DONE -> ch_count[0]=7 (5 RUN + 2 DRAIN); ch_count[2]=4 when the first RUN cycle carries an event; counts unchanged outside RUN and DRAIN.
- CNT_W=4, limit=15, ch_event[1] held high -> ch_count[1] saturates at 15 and ch_sat[1]=1; a restart via start clears both.
- Reset mid-run (rst at cyc=2), and start pulsed in RUN and DRAIN -> rst returns all outputs to 0 in the next cycle; start is ignored while busy; a start in DONE restarts with counters cleared.
- Build with TRACE_CYCLE_MONITOR_FINISH_EN defined -> finish message printed and simulation ends on the DONE entry cycle. Build without it -> simulation continues with done held.
